seg7_anim_scan: RTL and testbench
=================================

// Module: seg7_anim_scan
// PURPOSE
//  Multi-digit 7-segment animation engine with time-multiplexed digit scanning.
//  Generates frame and scan ticks from the board clock and steps one of several animations.
//  Drives the scanned seg/dig pins of the onboard display directly.
//  Successor to the single-digit spinner: N digits, selectable mode, direction, polarity.
// PARAMETERS
//  CLK_HZ          27_000_000  input clock frequency
//  NUM_DIGITS      4           digits on display, 1..8
//  FRAME_HZ        8           animation step rate
//  SCAN_HZ         1000        digit scan rate; legal range FRAME_HZ <= SCAN_HZ <= CLK_HZ/2
//  SEG_ACTIVE_LOW  1           1: lit segment drives 0
//  DIG_ACTIVE_LOW  1           1: selected digit drives 0
// PORTS
//  clk         in   1           system clock
//  rst         in   1           synchronous reset, active-high
//  en          in   1           1: animate; 0: freeze step, blank segments
//  mode        in   2           0 SPIN, 1 CHASE, 2 BLINK, 3 OFF
//  dir         in   1           0 forward, 1 reverse
//  seg         out  8           {dp,g,f,e,d,c,b,a}; polarity per SEG_ACTIVE_LOW
//  dig         out  NUM_DIGITS  one-hot digit select; digit 0 = rightmost
//  frame_tick  out  1           one-cycle pulse on every animation step
// BEHAVIOUR
//  Reset: step=0, scan_idx=0, prescalers=0, mode_q=OFF, frame_tick=0, seg=all-off, dig=all-off.
//  Ticks: frame prescaler terminal count FRAME_DIV=CLK_HZ/FRAME_HZ-1.
//   Scan prescaler terminal count SCAN_DIV=CLK_HZ/SCAN_HZ-1; each pulses one cycle at terminal count, then wraps to 0.
//  en=0: frame prescaler holds and step holds; scan continues; seg=all-off.
//  Mode/dir: sampled into mode_q/dir_q only on a frame tick.
//   Mode change resets step to 0 on that tick; no advance occurs on that tick.
//   Dir change keeps step and advances in the new direction on that tick.
//  Step: forward max->0 wrap; reverse 0->max wrap. max by mode: SPIN 5, CHASE 2N+3, BLINK 1, OFF 0.
//  SPIN: every digit shows one segment, a,b,c,d,e,f for step 0..5.
//  CHASE: one segment lit on the whole display, path around the perimeter:
//   step 0..N-1:     seg a, digit N-1-step (top, left to right)
//   step N, N+1:     b then c, digit 0
//   step N+2..2N+1:  seg d, digit step-(N+2) (bottom, right to left)
//   step 2N+2, 2N+3: e then f, digit N-1
//  BLINK: step 0 -> all 8 segments lit on all digits; step 1 -> all off.
//  OFF: seg all-off; scanning continues.
//  Scan: on scan tick, scan_idx increments and wraps N-1->0. seg and dig update together, registered.
//   Latency: exactly one clk after the scan tick (or frame tick).
//  frame_tick: registered, asserted in the cycle after frame prescaler terminal count.
//  Scan tick and frame tick in the same cycle: the new step applies to the new scan_idx on the same output edge.
//  Step width: $clog2(2*NUM_DIGITS+4); prescaler widths: $clog2(DIV+1).
//  rst mid-animation: all state to reset values on the next edge; animation restarts at step 0 once mode latched.
//  Elaboration-time check: NUM_DIGITS outside 1..8 or FRAME_HZ>SCAN_HZ -> $error.
// STRUCTURE
//  Package seg7_pkg:
//   anim_mode_e enum (SPIN, CHASE, BLINK, OFF)
//   segment bit index constants SEG_A..SEG_G, SEG_DP
//   spin pattern table
//  Sub-module seg7_tick_gen (param DIV; clk, rst, en -> tick): instantiated twice, frame and scan.
//  Top: step FSM, pattern generator (combinational per scan_idx), output polarity and registers.
// TESTING  (sim params: CLK_HZ=1000, FRAME_HZ=100, SCAN_HZ=500, NUM_DIGITS=4, active-low)
//  Reset:
//   hold rst 3 clks -> seg=8'hFF, dig=4'hF, frame_tick=0.
//   Release -> first frame_tick at cycle 10, dig=4'b1110 one cycle after the first scan tick.
//  SPIN forward:
//   mode=0, en=1 -> on each digit, seg walks 8'hFE,FD,FB,F7,EF,DF and repeats every 60 clks.
//   dir=1 -> reverse order, wrap 0->5.
//  CHASE:
//   mode=1 -> step 0 lights a on dig 4'b0111; step 4 lights b on dig 4'b1110.
//   Full loop is 12 frames (120 clks) and returns to step 0.
//  BLINK/en:
//   mode=2 -> seg alternates 8'h00/8'hFF every frame.
//   en=0 mid-frame -> seg=8'hFF, step frozen; en=1 -> resumes from the frozen step.
//  Mode change on a frame-tick cycle:
//   switch SPIN->CHASE at step 3 -> CHASE starts at step 0 on that tick.
//   OFF -> seg=8'hFF while dig keeps scanning.
//  Reset mid-CHASE at step 7 -> all outputs return to reset values next clk; step=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the scanned 7-segment animation engine.
// Segment bits are ordered {dp,g,f,e,d,c,b,a}; patterns here are active-high.
package seg7_pkg;

  typedef enum logic [1:0] {
    SPIN  = 2'd0,
    CHASE = 2'd1,
    BLINK = 2'd2,
    OFF   = 2'd3
  } anim_mode_e;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_ALL = 8'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) |
                                      (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G) | (1 << SEG_DP));

  // Entry [i] is the single segment lit by SPIN at step i.
  localparam logic [5:0][7:0] SPIN_TABLE = {
    8'(1 << SEG_F), 8'(1 << SEG_E), 8'(1 << SEG_D),
    8'(1 << SEG_C), 8'(1 << SEG_B), 8'(1 << SEG_A)
  };

  function automatic int step_max(anim_mode_e m, int n);
    case (m)
      SPIN:    return 5;
      CHASE:   return 2 * n + 3;
      BLINK:   return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler: one-cycle tick while the counter sits at DIV.
// The counter freezes when en is low, so a paused frame resumes mid-count.
module seg7_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [W-1:0] TERM = W'(DIV);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/seg7_anim_scan.sv
// Multi-digit 7-segment animation engine with time-multiplexed digit scanning.
// Step/mode state advances on frame ticks; seg/dig are re-registered from next-state values.
module seg7_anim_scan
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 27_000_000,
  parameter int NUM_DIGITS     = 4,
  parameter int FRAME_HZ       = 8,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  dir,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  frame_tick
);

  localparam int FRAME_DIV = CLK_HZ / FRAME_HZ - 1;
  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ - 1;
  localparam int STEP_W    = $clog2(2 * NUM_DIGITS + 4);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || FRAME_HZ > SCAN_HZ) begin : g_param_check
    $error("seg7_anim_scan: illegal parameters NUM_DIGITS=%0d FRAME_HZ=%0d SCAN_HZ=%0d",
           NUM_DIGITS, FRAME_HZ, SCAN_HZ);
  end

  logic frame_pulse;
  logic scan_pulse;

  seg7_tick_gen #(.DIV(FRAME_DIV)) u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (frame_pulse)
  );

  seg7_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (scan_pulse)
  );

  anim_mode_e            mode_q, mode_d;
  logic                  dir_q, dir_d;
  logic [STEP_W-1:0]     step_q, step_d, cur_max;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]      disp_idx_q, disp_idx_d;
  logic                  disp_on_q, disp_on_d;
  logic [7:0]            pat;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] dig_d;
  int                    s, d, n;

  assign cur_max = STEP_W'(step_max(mode_q, NUM_DIGITS));

  // A mode change restarts at step 0 without advancing; otherwise step in the latched direction.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    step_d = step_q;
    if (frame_pulse) begin
      dir_d = dir;
      if (anim_mode_e'(mode) != mode_q) begin
        mode_d = anim_mode_e'(mode);
        step_d = '0;
      end else if (dir) begin
        step_d = (step_q == '0) ? cur_max : step_q - STEP_W'(1);
      end else begin
        step_d = (step_q == cur_max) ? '0 : step_q + STEP_W'(1);
      end
    end
  end

  // disp_idx is the digit being shown; scan_idx is the one queued for the next scan tick.
  always_comb begin
    scan_idx_d = scan_idx_q;
    disp_idx_d = disp_idx_q;
    disp_on_d  = disp_on_q;
    if (scan_pulse) begin
      disp_idx_d = scan_idx_q;
      disp_on_d  = 1'b1;
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    pat = '0;
    s   = int'(step_d);
    d   = int'(disp_idx_d);
    n   = NUM_DIGITS;
    case (mode_d)
      SPIN: begin
        if (s < 6) pat = SPIN_TABLE[s[2:0]];
      end
      CHASE: begin
        // Perimeter walk: top row, right edge, bottom row, left edge.
        if (s < n) begin
          if (d == n - 1 - s) pat[SEG_A] = 1'b1;
        end else if (s == n) begin
          if (d == 0) pat[SEG_B] = 1'b1;
        end else if (s == n + 1) begin
          if (d == 0) pat[SEG_C] = 1'b1;
        end else if (s <= 2 * n + 1) begin
          if (d == s - (n + 2)) pat[SEG_D] = 1'b1;
        end else if (s == 2 * n + 2) begin
          if (d == n - 1) pat[SEG_E] = 1'b1;
        end else begin
          if (d == n - 1) pat[SEG_F] = 1'b1;
        end
      end
      BLINK: begin
        if (s == 0) pat = SEG_ALL;
      end
      default: pat = '0;
    endcase
    if (!en) pat = '0;
  end

  always_comb begin
    onehot = disp_on_d ? (NUM_DIGITS'(1) << disp_idx_d) : '0;
    seg_d  = SEG_ACTIVE_LOW ? ~pat : pat;
    dig_d  = DIG_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= OFF;
      dir_q      <= 1'b0;
      step_q     <= '0;
      scan_idx_q <= '0;
      disp_idx_q <= '0;
      disp_on_q  <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= SEG_OFF;
      dig        <= DIG_OFF;
    end else begin
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      scan_idx_q <= scan_idx_d;
      disp_idx_q <= disp_idx_d;
      disp_on_q  <= disp_on_d;
      frame_tick <= frame_pulse;
      seg        <= seg_d;
      dig        <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg7_anim_scan.sv
// Scoreboard bench for seg7_anim_scan: directed phases push hand-computed
// expectations keyed by clock edge; a negedge monitor pops and compares them.
module tb_seg7_anim_scan;

  localparam int K_SEG = 0;
  localparam int K_DIG = 1;
  localparam int K_FT  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd3;
  logic       dir = 1'b0;
  logic [7:0] seg;
  logic [3:0] dig;
  logic       frame_tick;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  seg7_anim_scan #(
    .CLK_HZ         (1000),
    .NUM_DIGITS     (4),
    .FRAME_HZ       (100),
    .SCAN_HZ        (500),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .dir        (dir),
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input int k, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Drive inputs 2 time units after posedge number 'at'.
  task automatic applyStimulus(input int at, input logic r, input logic e,
                               input logic [1:0] m, input logic d);
    while (cyc < at) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst  = r;
    en   = e;
    mode = m;
    dir  = d;
  endtask

  task automatic checkOutput();
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_SEG:   act = seg;
          K_DIG:   act = {4'h0, dig};
          default: act = {7'h0, frame_tick};
        endcase
        n_checks++;
        if (act === sb[i].val) n_pass++;
        else $display("[TB] FAIL %s @edge %0d: got %h, expected %h",
                      sb[i].name, cyc, act, sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got edge %0d, expected <= 420", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for edges 1..3.
    push_exp(3, K_SEG, 8'hFF, "rst_seg");
    push_exp(3, K_DIG, 8'h0F, "rst_dig");
    push_exp(3, K_FT,  8'h00, "rst_ft");

    // SPIN forward; first scan update at edge 5, first frame tick at edge 13.
    applyStimulus(3, 1'b0, 1'b1, 2'd0, 1'b0);
    push_exp(4,  K_DIG, 8'h0F, "dig_before_scan");
    push_exp(5,  K_DIG, 8'h0E, "first_scan_dig0");
    push_exp(7,  K_DIG, 8'h0D, "scan_dig1");
    push_exp(12, K_FT,  8'h00, "no_ft_before_10");
    push_exp(12, K_SEG, 8'hFF, "seg_off_before_latch");
    push_exp(13, K_FT,  8'h01, "first_ft_cycle10");
    push_exp(13, K_SEG, 8'hFE, "spin_s0");
    push_exp(13, K_DIG, 8'h0E, "spin_s0_dig");
    push_exp(14, K_FT,  8'h00, "ft_one_cycle");
    push_exp(23, K_SEG, 8'hFD, "spin_s1");
    push_exp(23, K_DIG, 8'h0D, "spin_s1_dig");
    push_exp(33, K_SEG, 8'hFB, "spin_s2");
    push_exp(43, K_SEG, 8'hF7, "spin_s3");
    push_exp(53, K_SEG, 8'hEF, "spin_s4");
    push_exp(63, K_SEG, 8'hDF, "spin_s5");
    push_exp(73, K_SEG, 8'hFE, "spin_wrap_s0");

    // Reverse: 0 wraps to 5.
    applyStimulus(74, 1'b0, 1'b1, 2'd0, 1'b1);
    push_exp(83,  K_SEG, 8'hDF, "spin_rev_wrap_s5");
    push_exp(93,  K_SEG, 8'hEF, "spin_rev_s4");
    push_exp(103, K_SEG, 8'hF7, "spin_rev_s3");

    // SPIN at step 3 -> CHASE at edge 113, starting at step 0.
    applyStimulus(104, 1'b0, 1'b1, 2'd1, 1'b0);
    push_exp(113, K_SEG, 8'hFF, "chase_s0_dig2_dark");
    push_exp(113, K_DIG, 8'h0B, "chase_s0_dig2");
    push_exp(115, K_SEG, 8'hFE, "chase_s0_a");
    push_exp(115, K_DIG, 8'h07, "chase_s0_a_dig3");
    push_exp(157, K_SEG, 8'hFD, "chase_s4_b");
    push_exp(157, K_DIG, 8'h0E, "chase_s4_b_dig0");
    push_exp(173, K_SEG, 8'hF7, "chase_s6_d");
    push_exp(173, K_DIG, 8'h0E, "chase_s6_d_dig0");
    push_exp(183, K_SEG, 8'hF7, "chase_s7_d");
    push_exp(183, K_DIG, 8'h0D, "chase_s7_d_dig1");
    push_exp(219, K_SEG, 8'hEF, "chase_s10_e");
    push_exp(219, K_DIG, 8'h07, "chase_s10_e_dig3");
    push_exp(235, K_SEG, 8'hFE, "chase_loop_s0");
    push_exp(235, K_DIG, 8'h07, "chase_loop_dig3");

    // BLINK alternates every frame.
    applyStimulus(236, 1'b0, 1'b1, 2'd2, 1'b0);
    push_exp(243, K_SEG, 8'h00, "blink_on");
    push_exp(243, K_DIG, 8'h07, "blink_on_dig3");
    push_exp(253, K_SEG, 8'hFF, "blink_off");
    push_exp(263, K_SEG, 8'h00, "blink_on2");

    // en=0 mid-frame: blank, frozen prescaler, scanning continues.
    applyStimulus(265, 1'b0, 1'b0, 2'd2, 1'b0);
    push_exp(270, K_SEG, 8'hFF, "en0_blank");
    push_exp(273, K_FT,  8'h00, "en0_no_ft");
    push_exp(275, K_DIG, 8'h07, "en0_scan_dig3");
    push_exp(277, K_DIG, 8'h0E, "en0_scan_dig0");

    // en=1: resume at frozen step 0, prescaler continues from 2.
    applyStimulus(285, 1'b0, 1'b1, 2'd2, 1'b0);
    push_exp(288, K_SEG, 8'h00, "resume_frozen_s0");
    push_exp(292, K_FT,  8'h00, "resume_no_ft_early");
    push_exp(293, K_FT,  8'h01, "resume_ft");
    push_exp(293, K_SEG, 8'hFF, "resume_s1");

    // OFF: segments dark while digits keep scanning.
    applyStimulus(294, 1'b0, 1'b1, 2'd3, 1'b0);
    push_exp(303, K_SEG, 8'hFF, "off_seg");
    push_exp(303, K_DIG, 8'h0D, "off_dig1");
    push_exp(305, K_DIG, 8'h0B, "off_dig2");
    push_exp(313, K_SEG, 8'hFF, "off_seg_stays");

    // Second CHASE run, reset at step 7.
    applyStimulus(314, 1'b0, 1'b1, 2'd1, 1'b0);
    push_exp(399, K_SEG, 8'hF7, "chase2_s7_d");
    push_exp(399, K_DIG, 8'h0D, "chase2_s7_dig1");
    applyStimulus(399, 1'b1, 1'b1, 2'd1, 1'b0);
    push_exp(400, K_SEG, 8'hFF, "midrst_seg");
    push_exp(400, K_DIG, 8'h0F, "midrst_dig");
    push_exp(400, K_FT,  8'h00, "midrst_ft");

    applyStimulus(400, 1'b0, 1'b1, 2'd1, 1'b0);
    push_exp(401, K_DIG, 8'h0F, "rel_dig_off");
    push_exp(402, K_DIG, 8'h0E, "rel_first_scan");
    push_exp(409, K_FT,  8'h00, "rel_no_ft");
    push_exp(409, K_SEG, 8'hFF, "rel_seg_off");
    push_exp(410, K_FT,  8'h01, "rel_ft");
    push_exp(416, K_SEG, 8'hFE, "rel_chase_s0_a");
    push_exp(416, K_DIG, 8'h07, "rel_chase_s0_dig3");

    applyStimulus(420, 1'b0, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    while (sb.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL %s never compared: got no sample at edge %0d, expected one",
               sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
